// File: rtl/macc_dot_product_ctrl.sv
// Dot-product sequencer: streams operand pairs from two sync-read RAMs into an
// external latency-1 MAC, drains the MAC pipeline and presents the sum on a valid/ready port.
module macc_dot_product_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] y_base,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] y_data,
  output logic              mac_clr,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_r, x_base_r, y_base_r;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [1:0]        drain_cnt, drain_cnt_nxt;
  logic              capture;
  logic              vld_p1;

  // Command parameters are held for the whole command; only written in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      len_r    <= len;
      x_base_r <= x_base;
      y_base_r <= y_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      mac_clr   <= 1'b0;
      vld_p1    <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      drain_cnt <= drain_cnt_nxt;
      mac_clr   <= (state_nxt == CLEAR);
      vld_p1    <= rd_en;
      if (capture) result <= mac_acc;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    drain_cnt_nxt = drain_cnt;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        drain_cnt_nxt = '0;
        state_nxt     = (len_r != '0) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        idx_nxt = idx + 1'b1;
        if (idx == len_r - 1'b1) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Three cycles: RAM read, MAC input register, accumulate.
        drain_cnt_nxt = drain_cnt + 1'b1;
        if (drain_cnt == 2'd2) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign rd_en        = (state == ISSUE);
  assign x_addr       = rd_en ? x_base_r + idx : '0;
  assign y_addr       = rd_en ? y_base_r + idx : '0;
  assign result_valid = (state == DONE);

  // ---- p1: read data returns; zero operands keep the MAC idle otherwise ----
  assign mac_a = vld_p1 ? x_data : '0;
  assign mac_b = vld_p1 ? y_data : '0;

endmodule

// File: tb/tb_macc_dot_product_ctrl.sv
// Directed bench for macc_dot_product_ctrl with behavioural RAMs and a latency-1 MAC.
module tb_macc_dot_product_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len, x_base, y_base;
  logic        busy, rd_en, mac_clr, result_valid, result_ready;
  logic [7:0]  x_addr, y_addr;
  logic [15:0] x_data, y_data, mac_a, mac_b;
  logic [47:0] mac_acc, result;

  logic [15:0] xmem [256];
  logic [15:0] ymem [256];
  logic [15:0] ar, br;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  macc_dot_product_ctrl #(.DATA_W(16), .ADDR_W(8), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .x_base(x_base), .y_base(y_base),
    .busy(busy), .rd_en(rd_en), .x_addr(x_addr), .y_addr(y_addr),
    .x_data(x_data), .y_data(y_data), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= xmem[x_addr];
      y_data <= ymem[y_addr];
    end
  end

  // Latency-1 MAC: operands registered, then accumulated one cycle later.
  always @(posedge clk) begin
    ar <= mac_a;
    br <= mac_b;
    if (mac_clr) mac_acc <= '0;
    else         mac_acc <= mac_acc + 48'(ar) * 48'(br);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},    64'(busy), 64'(0));
    chk({tag, " rd_en"},   64'(rd_en), 64'(0));
    chk({tag, " x_addr"},  64'(x_addr), 64'(0));
    chk({tag, " y_addr"},  64'(y_addr), 64'(0));
    chk({tag, " mac_clr"}, 64'(mac_clr), 64'(0));
    chk({tag, " mac_a"},   64'(mac_a), 64'(0));
    chk({tag, " mac_b"},   64'(mac_b), 64'(0));
    chk({tag, " result"},  64'(result), 64'(0));
    chk({tag, " rvalid"},  64'(result_valid), 64'(0));
  endtask

  // Runs one command cycle by cycle. hold>0 holds result_ready low in DONE for
  // hold cycles, pokes start while busy, and pokes start in the handshake cycle.
  task automatic run_cmd(input logic [7:0] n, input logic [7:0] xb, input logic [7:0] yb,
                         input logic [47:0] exp, input int hold);
    logic [7:0] ea, eb;
    @(posedge clk); #1;
    start = 1'b1; len = n; x_base = xb; y_base = yb; result_ready = (hold == 0);
    for (int c = 1; c <= int'(n) + 5; c++) begin
      @(posedge clk); #1;
      start  = (hold != 0 && c == 3);
      len    = 8'hAA; x_base = 8'h55; y_base = 8'h33;
      chk("busy", 64'(busy), 64'(1));
      chk("mac_clr", 64'(mac_clr), 64'(c == 1));
      chk("rd_en", 64'(rd_en), 64'(c >= 2 && c <= int'(n) + 1));
      if (c >= 2 && c <= int'(n) + 1) begin
        ea = xb + 8'(c - 2);
        eb = yb + 8'(c - 2);
        chk("x_addr", 64'(x_addr), 64'(ea));
        chk("y_addr", 64'(y_addr), 64'(eb));
      end
      if (c >= 3 && c <= int'(n) + 2) begin
        ea = xb + 8'(c - 3);
        eb = yb + 8'(c - 3);
        chk("mac_a", 64'(mac_a), 64'(xmem[ea]));
        chk("mac_b", 64'(mac_b), 64'(ymem[eb]));
      end else begin
        chk("mac_a idle", 64'(mac_a), 64'(0));
      end
      chk("result_valid", 64'(result_valid), 64'(c == int'(n) + 5));
    end
    chk("result", 64'(result), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold rvalid", 64'(result_valid), 64'(1));
      chk("hold result", 64'(result), 64'(exp));
    end
    if (hold != 0) begin
      result_ready = 1'b1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("after rvalid", 64'(result_valid), 64'(0));
    chk("after busy", 64'(busy), 64'(0));
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; x_base = '0; y_base = '0; result_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    #3;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1*5 + 2*6 + 3*7 + 4*8 = 70
    xmem[0] = 16'd1; xmem[1] = 16'd2; xmem[2] = 16'd3; xmem[3] = 16'd4;
    ymem[0] = 16'd5; ymem[1] = 16'd6; ymem[2] = 16'd7; ymem[3] = 16'd8;
    run_cmd(8'd4, 8'h00, 8'h00, 48'd70, 0);

    run_cmd(8'd0, 8'h00, 8'h00, 48'd0, 0);

    // x at FE,FF,00,01 = 2,3,1,2 ; y at 10..13 = 1,2,3,4 -> 2+6+3+8 = 19
    xmem[8'hFE] = 16'd2; xmem[8'hFF] = 16'd3;
    xmem[8'h00] = 16'd1; xmem[8'h01] = 16'd2;
    ymem[8'h10] = 16'd1; ymem[8'h11] = 16'd2; ymem[8'h12] = 16'd3; ymem[8'h13] = 16'd4;
    run_cmd(8'd4, 8'hFE, 8'h10, 48'd19, 0);

    // Backpressure, then an independent command: 10*3 + 20*4 = 110
    xmem[0] = 16'd1; xmem[1] = 16'd2; xmem[2] = 16'd3; xmem[3] = 16'd4;
    run_cmd(8'd4, 8'h00, 8'h00, 48'd70, 10);
    xmem[8'h20] = 16'd10; xmem[8'h21] = 16'd20;
    ymem[8'h40] = 16'd3;  ymem[8'h41] = 16'd4;
    run_cmd(8'd2, 8'h20, 8'h40, 48'd110, 0);

    // 255 * 0xFFFE0001 = 0xFE_FE02_00FF
    for (int i = 0; i < 256; i++) begin
      xmem[i] = 16'hFFFF;
      ymem[i] = 16'hFFFF;
    end
    run_cmd(8'd255, 8'h00, 8'h00, 48'h00FE_FE02_00FF, 0);

    // Abort mid-ISSUE with reset, then rerun on the original data.
    xmem[0] = 16'd1; xmem[1] = 16'd2; xmem[2] = 16'd3; xmem[3] = 16'd4;
    ymem[0] = 16'd5; ymem[1] = 16'd6; ymem[2] = 16'd7; ymem[3] = 16'd8;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd4; x_base = 8'h00; y_base = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-abort rd_en", 64'(rd_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(8'd4, 8'h00, 8'h00, 48'd70, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
